// File: rtl/gen_mode_arbiter.sv
// -----------------------------------------------------------------------------
// gen_mode_arbiter
//
// N-channel valid/ready arbiter feeding one downstream consumer through a
// single registered output stage. The arbitration policy is picked at
// elaboration time by MODE:
//   MODE 0 : fixed priority, channel 0 highest
//   MODE 1 : round-robin, search starts at rr_ptr and wraps N-1 -> 0
// Any other MODE value stops elaboration.
//
// Optional packet lock, enabled by defining GEN_MODE_ARBITER_LOCK_EN:
//   once a beat with in_last=0 is taken from channel g, only g can be granted
//   until its in_last=1 beat is taken. In MODE 1 the round-robin pointer then
//   only advances on that releasing beat. Without the macro arbitration is
//   strictly per beat and in_last only travels to out_last.
//
// Parameters:
//   N    number of input channels (2..16)
//   W    data width per channel
//   MODE 0 = fixed priority, 1 = round-robin
//   CW   channel index width, derived from N
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   [N]    per-channel valid
//   in_ready   [N]    per-channel ready, one-hot or zero
//   in_data    [N*W]  channel i at bits [i*W +: W]
//   in_last    [N]    per-channel end-of-packet marker
//   out_valid         output register holds a beat
//   out_ready         consumer accepts the held beat
//   out_data   [W]    registered data
//   out_chan   [CW]   source channel of the held beat
//   out_last          registered last flag
// -----------------------------------------------------------------------------
module gen_mode_arbiter #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int MODE = 0,
  parameter int CW   = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic [CW-1:0]   out_chan,
  output logic            out_last
);

  // Successor channel index with wrap from N-1 back to 0.
  function automatic logic [CW-1:0] next_chan(input logic [CW-1:0] c);
    if (c == CW'(N - 1)) begin
      return '0;
    end
    return c + CW'(1);
  endfunction

  // Output stage registers.
  logic            vld_p1;
  logic [W-1:0]    out_data_p1;
  logic [CW-1:0]   out_chan_p1;
  logic            out_last_p1;

  // Arbitration signals.
  logic            accept;
  logic [N-1:0]    req;
  logic            grant_any;
  logic [CW-1:0]   grant_idx;
  logic            xfer;
  logic [W-1:0]    sel_data;
  logic            sel_last;

  // The output register can take a new beat when empty or being drained.
  assign accept = ~vld_p1 | out_ready;
  // rst gating keeps in_ready low for the whole reset pulse, not just the
  // edge-aligned part of it.
  assign xfer   = grant_any & accept & ~rst;

  // ---------------------------------------------------------------------------
  // Stage 0: request masking (packet lock), grant selection, input mux
  // ---------------------------------------------------------------------------
`ifdef GEN_MODE_ARBITER_LOCK_EN
  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_t;

  lock_state_t   lock_state;
  lock_state_t   lock_state_nxt;
  logic [CW-1:0] lock_chan;
  logic [CW-1:0] lock_chan_nxt;
  logic [N-1:0]  lock_onehot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_state <= LOCK_IDLE;
      lock_chan  <= '0;
    end else begin
      lock_state <= lock_state_nxt;
      lock_chan  <= lock_chan_nxt;
    end
  end

  // A non-last beat opens (or keeps) the lock on its channel; a last beat
  // drops it. Cycles without a transfer leave the lock untouched, so an idle
  // locked channel still blocks everyone else.
  always_comb begin
    lock_state_nxt = lock_state;
    lock_chan_nxt  = lock_chan;
    if (xfer) begin
      lock_chan_nxt  = grant_idx;
      lock_state_nxt = sel_last ? LOCK_IDLE : LOCK_HELD;
    end
  end

  always_comb begin
    lock_onehot = {{(N-1){1'b0}}, 1'b1} << lock_chan;
    req         = in_valid;
    if (lock_state == LOCK_HELD) begin
      req = in_valid & lock_onehot;
    end
  end
`else
  assign req = in_valid;
`endif

  generate
    if (N < 2 || N > 16) begin : g_bad_n
      $error("gen_mode_arbiter: N must be in 2..16");
    end

    if (MODE == 0) begin : g_fixed
      // Scan high to low so the lowest requesting index is the last writer.
      always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
          if (req[i]) begin
            grant_any = 1'b1;
            grant_idx = CW'(i);
          end
        end
      end
    end else if (MODE == 1) begin : g_rr
      logic [CW-1:0] rr_ptr;
      logic [N-1:0]  req_rot;
      logic [CW:0]   ofs;
      logic [CW:0]   sum;
      logic          hit;
      logic          adv;

`ifdef GEN_MODE_ARBITER_LOCK_EN
      // Packets are the unit of fairness: move on only after the last beat.
      assign adv = xfer & sel_last;
`else
      assign adv = xfer;
`endif

      // Rotate requests so rr_ptr lands on bit 0, priority-encode the lowest
      // set bit, then rotate the winning offset back to a channel index.
      always_comb begin
        req_rot = N'({req, req} >> rr_ptr);
        hit     = 1'b0;
        ofs     = '0;
        for (int j = N - 1; j >= 0; j--) begin
          if (req_rot[j]) begin
            hit = 1'b1;
            ofs = (CW+1)'(j);
          end
        end
        sum = {1'b0, rr_ptr} + ofs;
        if (sum >= (CW+1)'(N)) begin
          sum = sum - (CW+1)'(N);
        end
        grant_any = hit;
        grant_idx = CW'(sum);
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rr_ptr <= '0;
        end else if (adv) begin
          rr_ptr <= next_chan(grant_idx);
        end
      end
    end else begin : g_bad_mode
      $error("gen_mode_arbiter: MODE must be 0 or 1");
    end
  endgenerate

  // Data and last of the granted channel; other channels are ignored.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == CW'(i)) begin
        sel_data = in_data[i*W +: W];
        sel_last = in_last[i];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = xfer && (grant_idx == CW'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      out_data_p1 <= '0;
      out_chan_p1 <= '0;
      out_last_p1 <= 1'b0;
    end else if (xfer) begin
      vld_p1      <= 1'b1;
      out_data_p1 <= sel_data;
      out_chan_p1 <= grant_idx;
      out_last_p1 <= sel_last;
    end else if (out_ready) begin
      vld_p1      <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = out_data_p1;
  assign out_chan  = out_chan_p1;
  assign out_last  = out_last_p1;

endmodule

// File: tb/tb_gen_mode_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gen_mode_arbiter
//
// Drives one fixed-priority (MODE 0) and one round-robin (MODE 1) instance
// from the same producer/consumer stimulus. A reference model picks the
// expected winner per cycle from the arbitration rules, predicts in_ready and
// out_valid, and queues each expected beat; a monitor pops the queue whenever
// a beat leaves an instance and compares it.
// -----------------------------------------------------------------------------
module tb_gen_mode_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 2;
`ifdef GEN_MODE_ARBITER_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   in_valid = '0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_last = '0;
  logic           out_ready = 1'b0;

  logic [N-1:0]   in_ready_m0, in_ready_m1;
  logic           out_valid_m0, out_valid_m1;
  logic [W-1:0]   out_data_m0, out_data_m1;
  logic [CW-1:0]  out_chan_m0, out_chan_m1;
  logic           out_last_m0, out_last_m1;

  always #5 clk = ~clk;

  gen_mode_arbiter #(.N(N), .W(W), .MODE(0)) dut_fp (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_m0), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_m0), .out_ready(out_ready), .out_data(out_data_m0),
    .out_chan(out_chan_m0), .out_last(out_last_m0)
  );

  gen_mode_arbiter #(.N(N), .W(W), .MODE(1)) dut_rr (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_m1), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_m1), .out_ready(out_ready), .out_data(out_data_m1),
    .out_chan(out_chan_m1), .out_last(out_last_m1)
  );

  typedef struct {
    int           chan;
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];

  // Reference model state, index 0 = fixed priority, 1 = round-robin.
  bit full[2];
  int rr[2];
  bit lk[2];
  int lkch[2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      full[m] = 1'b0;
      rr[m]   = 0;
      lk[m]   = 1'b0;
      lkch[m] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  // Winner = requesting (and lock-eligible) channel with the smallest
  // distance; distance is the index itself for fixed priority and the
  // circular distance from the pointer for round-robin.
  function automatic int model_grant(input int m, input logic [N-1:0] v);
    int best   = -1;
    int best_d = N;
    int d;
    logic [N-1:0] t;
    for (int i = 0; i < N; i++) begin
      t = v >> i;
      if (t[0] && (!lk[m] || i == lkch[m])) begin
        d = (m == 0) ? i : (i - rr[m] + N) % N;
        if (d < best_d) begin
          best_d = d;
          best   = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [N*W-1:0] rnd_data();
    logic [N*W-1:0] r = '0;
    for (int i = 0; i < N; i++) r = {r[N*W-W-1:0], W'($urandom)};
    return r;
  endfunction

  // One clock cycle: apply inputs just after the edge, predict and check at
  // the falling edge, then advance the model to what the next edge commits.
  task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d,
                      input logic [N-1:0] l, input logic ordy);
    int           g;
    logic         acc;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] lt;
    beat_t        b;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = ordy;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      acc     = !full[m] || ordy;
      g       = model_grant(m, v);
      exp_rdy = (acc && g >= 0) ? (N'(1) << g) : '0;
      if (m == 0) begin
        check("in_ready_fp", 64'(in_ready_m0), 64'(exp_rdy));
        check("out_valid_fp", 64'(out_valid_m0), 64'(full[m]));
      end else begin
        check("in_ready_rr", 64'(in_ready_m1), 64'(exp_rdy));
        check("out_valid_rr", 64'(out_valid_m1), 64'(full[m]));
      end
      if (acc && g >= 0) begin
        lt     = l >> g;
        b.chan = g;
        b.data = W'(d >> (g * W));
        b.last = lt[0];
        if (m == 0) q0.push_back(b);
        else        q1.push_back(b);
        full[m] = 1'b1;
        if (LOCK) begin
          lk[m]   = !b.last;
          lkch[m] = g;
        end
        if (m == 1 && (!LOCK || b.last)) rr[m] = (g + 1) % N;
      end else if (ordy) begin
        full[m] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pop_cmp(input int m);
    beat_t b;
    if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
      check(m ? "rr_unexpected_beat" : "fp_unexpected_beat", 64'd1, 64'd0);
    end else begin
      if (m == 0) begin
        b = q0.pop_front();
        check("fp_chan", 64'(out_chan_m0), 64'(b.chan));
        check("fp_data", 64'(out_data_m0), 64'(b.data));
        check("fp_last", 64'(out_last_m0), 64'(b.last));
      end else begin
        b = q1.pop_front();
        check("rr_chan", 64'(out_chan_m1), 64'(b.chan));
        check("rr_data", 64'(out_data_m1), 64'(b.data));
        check("rr_last", 64'(out_last_m1), 64'(b.last));
      end
    end
  endtask

  // Monitor: a beat leaves when out_valid & out_ready at the coming edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid_m0 && out_ready) pop_cmp(0);
        if (out_valid_m1 && out_ready) pop_cmp(1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic pulse_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [N*W-1:0] d;
  logic [N-1:0]   v, l;
  int             fair_seq[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    model_reset();
    in_valid = '1;
    #3;
    check("rst_in_ready_fp", 64'(in_ready_m0), 64'd0);
    check("rst_in_ready_rr", 64'(in_ready_m1), 64'd0);
    check("rst_out_valid", 64'({out_valid_m0, out_valid_m1}), 64'd0);
    check("rst_out_regs", 64'({out_data_m0, out_chan_m0, out_last_m0}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after release: nothing granted, nothing emitted.
    repeat (3) step('0, rnd_data(), '0, 1'b1);

    // Asynchronous reset while a beat is held.
    step(4'b0100, rnd_data(), 4'b1111, 1'b1);
    step(4'b0000, rnd_data(), 4'b0000, 1'b0);
    check("pre_rst_chan", 64'(out_chan_m0), 64'd2);
    in_valid = '1;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'({out_valid_m0, out_valid_m1}), 64'd0);
    check("midrst_out_chan", 64'({out_chan_m0, out_chan_m1}), 64'd0);
    check("midrst_in_ready", 64'({in_ready_m0, in_ready_m1}), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fixed priority with channels 1 and 3 requesting.
    d = rnd_data();
    step(4'b1010, d, 4'b1111, 1'b1);
    check("fp_1010_chan", 64'(out_chan_m0), 64'd1);
    check("fp_1010_data", 64'(out_data_m0), 64'(d[15:8]));
    repeat (3) step(4'b1010, rnd_data(), 4'b1111, 1'b1);

    // Round-robin fairness from a fresh pointer.
    pulse_reset();
    for (int k = 0; k < 6; k++) begin
      step(4'b1111, rnd_data(), 4'b1111, 1'b1);
      check("rr_fair_seq", 64'(out_chan_m1), 64'(fair_seq[k]));
    end
    repeat (4) step(4'b1001, rnd_data(), 4'b1111, 1'b1);
    // Wrap: only channel 3, then channels 0 and 3.
    step(4'b1000, rnd_data(), 4'b1111, 1'b1);
    step(4'b1001, rnd_data(), 4'b1111, 1'b1);
    check("rr_wrap_chan", 64'(out_chan_m1), 64'd0);

    // Backpressure: one beat held for 5 cycles, then drained with no bubble.
    step(4'b1000, rnd_data(), 4'b1111, 1'b1);
    repeat (5) step(4'b1111, rnd_data(), 4'b1111, 1'b0);
    repeat (3) step(4'b1111, rnd_data(), 4'b1111, 1'b1);

    // Packet from channel 2 (last on third beat) while channel 0 waits.
    pulse_reset();
    step(4'b0100, rnd_data(), 4'b0000, 1'b1);
    step(4'b0101, rnd_data(), 4'b0000, 1'b1);
    step(4'b0101, rnd_data(), 4'b0100, 1'b1);
    step(4'b0001, rnd_data(), 4'b1111, 1'b1);
    step(4'b0000, rnd_data(), 4'b1111, 1'b1);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      v = N'($urandom);
      if ($urandom_range(0, 3) == 0) v = v & N'($urandom);
      l = N'($urandom) & N'($urandom);
      step(v, rnd_data(), l, ($urandom_range(0, 9) < 7));
    end

    // Drain and confirm nothing expected is left behind.
    repeat (4) step('0, rnd_data(), '0, 1'b1);
    check("fp_queue_empty", 64'(q0.size()), 64'd0);
    check("rr_queue_empty", 64'(q1.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
